// File: rtl/max_pool_layer_pkg.sv
// Shared types and constants for the 2x2/stride-2 max-pooling stage.
package max_pool_layer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          FP_SIGN_BIT = 31;
    localparam logic [31:0] FP_ZERO     = 32'h0;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pool_max2.sv
// Combinational two-input max; on equality input a is selected.
module pool_max2
    import max_pool_layer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FLOAT_MODE = 1
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_y
);

    logic w_b_wins;

    generate
        if (FLOAT_MODE != 0) begin : g_float
            logic [FP_SIGN_BIT-1:0] w_ma;
            logic [FP_SIGN_BIT-1:0] w_mb;
            assign w_ma = i_a[FP_SIGN_BIT-1:0];
            assign w_mb = i_b[FP_SIGN_BIT-1:0];

            // Sign-magnitude ordering on raw bits; +0 and -0 tie so a keeps them.
            always_comb begin
                w_b_wins = 1'b0;
                case ({i_a[FP_SIGN_BIT], i_b[FP_SIGN_BIT]})
                    2'b00:   w_b_wins = (w_mb > w_ma);
                    2'b11:   w_b_wins = (w_mb < w_ma);
                    2'b10:   w_b_wins = (w_ma != '0) || (w_mb != '0);
                    default: w_b_wins = 1'b0;
                endcase
            end
        end else begin : g_int
            assign w_b_wins = ($signed(i_b) > $signed(i_a));
        end
    endgenerate

    assign o_y = w_b_wins ? i_b : i_a;

endmodule

// File: rtl/max_pool_layer.sv
// Frame-based 2x2/stride-2 max pooling with optional ReLU; one pooled pixel per clock.
module max_pool_layer
    import max_pool_layer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FLOAT_MODE = 1,
    parameter int H          = 28,
    parameter int W          = 28,
    parameter int RELU       = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic [0:H*W*DATA_WIDTH-1]               img,
    output logic                                    busy,
    output logic                                    done,
    output logic [0:(H/2)*(W/2)*DATA_WIDTH-1]       res
);

    localparam int OH   = H / 2;
    localparam int OW   = W / 2;
    localparam int NPIX = OH * OW;
    localparam int IW   = cnt_w(OH);
    localparam int JW   = cnt_w(OW);
    localparam int PW   = cnt_w(NPIX);
    localparam int FW   = cnt_w(H * W);
    localparam int SB   = (FLOAT_MODE != 0) ? FP_SIGN_BIT : DATA_WIDTH - 1;

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_frame [H*W];
    logic [DATA_WIDTH-1:0]   r_res   [NPIX];
    logic [IW-1:0]           r_i;
    logic [JW-1:0]           r_j;
    logic [PW-1:0]           r_widx;
    logic                    r_act;
    logic                    r_vld;
    logic [DATA_WIDTH-1:0]   r_pix;
    logic                    r_busy;
    logic                    r_done;

    logic [FW-1:0]           w_base;
    logic [DATA_WIDTH-1:0]   w_win [4];
    logic [DATA_WIDTH-1:0]   w_m01;
    logic [DATA_WIDTH-1:0]   w_m23;
    logic [DATA_WIDTH-1:0]   w_max;
    logic [DATA_WIDTH-1:0]   w_pool;
    logic                    w_last_ij;

    // Window in order (2i,2j), (2i,2j+1), (2i+1,2j), (2i+1,2j+1).
    always_comb begin
        w_base   = FW'(2 * int'(r_i) * W + 2 * int'(r_j));
        w_win[0] = r_frame[w_base];
        w_win[1] = r_frame[w_base + FW'(1)];
        w_win[2] = r_frame[w_base + FW'(W)];
        w_win[3] = r_frame[w_base + FW'(W + 1)];
    end

    pool_max2 #(.DATA_WIDTH(DATA_WIDTH), .FLOAT_MODE(FLOAT_MODE)) u_max_top (
        .i_a(w_win[0]), .i_b(w_win[1]), .o_y(w_m01)
    );
    pool_max2 #(.DATA_WIDTH(DATA_WIDTH), .FLOAT_MODE(FLOAT_MODE)) u_max_bot (
        .i_a(w_win[2]), .i_b(w_win[3]), .o_y(w_m23)
    );
    pool_max2 #(.DATA_WIDTH(DATA_WIDTH), .FLOAT_MODE(FLOAT_MODE)) u_max_out (
        .i_a(w_m01), .i_b(w_m23), .o_y(w_max)
    );

    assign w_pool    = ((RELU != 0) && w_max[SB]) ? DATA_WIDTH'(FP_ZERO) : w_max;
    assign w_last_ij = (r_i == IW'(OH - 1)) && (r_j == JW'(OW - 1));

    // Stage 1 registers the pooled pixel, stage 2 writes it into res.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_i     <= '0;
            r_j     <= '0;
            r_widx  <= '0;
            r_act   <= 1'b0;
            r_vld   <= 1'b0;
            r_pix   <= '0;
            for (int k = 0; k < H * W; k++) r_frame[k] <= '0;
            for (int k = 0; k < NPIX; k++)  r_res[k]   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        for (int k = 0; k < H * W; k++)
                            r_frame[k] <= img[k*DATA_WIDTH +: DATA_WIDTH];
                        r_i     <= '0;
                        r_j     <= '0;
                        r_widx  <= '0;
                        r_act   <= 1'b1;
                        r_vld   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_vld <= r_act;
                    if (r_act) begin
                        r_pix <= w_pool;
                        if (w_last_ij) begin
                            r_act <= 1'b0;
                        end else if (r_j == JW'(OW - 1)) begin
                            r_j <= '0;
                            r_i <= r_i + 1'b1;
                        end else begin
                            r_j <= r_j + 1'b1;
                        end
                    end
                    if (r_vld) begin
                        r_res[r_widx] <= r_pix;
                        r_widx        <= r_widx + 1'b1;
                        if (r_widx == PW'(NPIX - 1)) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;

    generate
        for (genvar k = 0; k < NPIX; k++) begin : g_res
            assign res[k*DATA_WIDTH +: DATA_WIDTH] = r_res[k];
        end
    endgenerate

endmodule

// File: tb/tb_max_pool_layer.sv
// Randomized scoreboard bench: four instances (int/float x ReLU off/on) pool the same frames.
module tb_max_pool_layer;

    localparam int H  = 5;
    localparam int W  = 7;
    localparam int DW = 32;
    localparam int OH = H / 2;
    localparam int OW = W / 2;
    localparam int NP = OH * OW;
    localparam int IW = H * W * DW;
    localparam int RW = NP * DW;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [0:IW-1]   img = '0;
    logic [3:0]      busy_v;
    logic [3:0]      done_v;
    logic [0:RW-1]   res_v [4];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [0:RW-1] r [4];
        int            t;
    } exp_t;

    exp_t          sb[$];
    logic [0:RW-1] last_r [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        max_pool_layer #(
            .DATA_WIDTH(DW), .FLOAT_MODE(g / 2), .H(H), .W(W), .RELU(g % 2)
        ) u_dut (
            .clk(clk), .rst(rst), .start(start), .img(img),
            .busy(busy_v[g]), .done(done_v[g]), .res(res_v[g])
        );
    end

    task automatic chkv(input string nm, input logic [0:RW-1] act, input logic [0:RW-1] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Reference: IEEE-754 single decoded to a real number.
    function automatic real f2r(input logic [31:0] x);
        int  e = int'(x[30:23]);
        real m = real'(x[22:0]) / 8388608.0;
        real v = (e == 0) ? m * 2.0 ** (-126) : (1.0 + m) * 2.0 ** (e - 127);
        return x[31] ? -v : v;
    endfunction

    function automatic bit gt(input logic [31:0] a, input logic [31:0] b, input int fl);
        if (fl != 0) return f2r(a) > f2r(b);
        return $signed(a) > $signed(b);
    endfunction

    function automatic logic [0:RW-1] model(input logic [0:IW-1] f, input int fl, input int relu);
        logic [0:RW-1] r = '0;
        logic [31:0]   best;
        logic [31:0]   e;
        for (int i = 0; i < OH; i++)
            for (int j = 0; j < OW; j++) begin
                best = f[((2*i)*W + 2*j)*DW +: DW];
                for (int di = 0; di < 2; di++)
                    for (int dj = 0; dj < 2; dj++) begin
                        e = f[((2*i+di)*W + 2*j+dj)*DW +: DW];
                        if (gt(e, best, fl)) best = e;
                    end
                if (relu != 0 && best[31]) best = 32'h0;
                r[(i*OW+j)*DW +: DW] = best;
            end
        return r;
    endfunction

    function automatic logic [31:0] rnd_elem();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return {1'($urandom), 8'(124 + $urandom_range(0, 3)), 23'($urandom_range(0, 3))};
            default: return {1'($urandom), 8'(118 + $urandom_range(0, 19)), 23'($urandom)};
        endcase
    endfunction

    function automatic logic [0:IW-1] rnd_frame(input bit neg, input bit edge_big);
        logic [0:IW-1] f;
        logic [31:0]   e;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                e = rnd_elem();
                if (neg) e[31] = 1'b1;
                if (edge_big && (r == H - 1 || c == W - 1)) e = 32'h7F00_0000;
                f[(r*W+c)*DW +: DW] = e;
            end
        return f;
    endfunction

    task automatic start_frame(input logic [0:IW-1] f);
        exp_t e;
        img   = f;
        start = 1'b1;
        for (int g = 0; g < 4; g++) e.r[g] = model(f, g / 2, g % 2);
        e.t = cyc + NP + 2;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chki("wait_done_timeout", sb.size(), 0);
            sb.delete();
        end
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && done_v != 4'h0) begin
            if (sb.size() == 0) begin
                chki("unexpected_done", int'(done_v), 0);
            end else begin
                e = sb.pop_front();
                chki("done_all", int'(done_v), 15);
                chki("done_cycle", cyc, e.t);
                chki("busy_at_done", int'(busy_v), 0);
                for (int g = 0; g < 4; g++)
                    chkv($sformatf("res_inst%0d", g), res_v[g], e.r[g]);
                last_r = e.r;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin
        logic [0:IW-1] f;
        logic [0:RW-1] tmp;
        logic [0:RW-1] nw;

        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) chkv($sformatf("rst_res%0d", g), res_v[g], '0);
        chki("rst_busy", int'(busy_v), 0);
        chki("rst_done", int'(done_v), 0);

        // start issued in the same cycle reset is released
        f   = rnd_frame(1'b0, 1'b0);
        rst = 1'b1;
        start_frame(f);
        @(posedge clk);
        #1 chki("busy_run", int'(busy_v), 15);
        wait_idle();

        for (int it = 0; it < 24; it++) begin
            f = rnd_frame(it % 4 == 1, it % 4 == 2);
            start_frame(f);
            wait_idle();
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        // img changes after capture and a second start during RUN are ignored
        f = rnd_frame(1'b0, 1'b0);
        start_frame(f);
        img = rnd_frame(1'b0, 1'b0);
        @(posedge clk);
        #1 start = 1'b1;
        img = rnd_frame(1'b1, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle();

        // start while DONE is ignored
        f = rnd_frame(1'b0, 1'b0);
        start_frame(f);
        repeat (NP + 1) @(posedge clk);
        #1 start = 1'b1;
        img = rnd_frame(1'b0, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (NP + 4) @(posedge clk);
        #1 chki("start_in_done_ignored", int'(busy_v), 0);
        chki("sb_after_done_start", sb.size(), 0);

        // res holds in IDLE
        repeat (5) @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) chkv($sformatf("hold%0d", g), res_v[g], last_r[g]);

        // only element 0 is rewritten after the first write edge
        f = rnd_frame(1'b0, 1'b0);
        start_frame(f);
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            nw = model(f, g / 2, g % 2);
            tmp = last_r[g];
            tmp[0 +: DW] = nw[0 +: DW];
            chkv($sformatf("partial%0d", g), res_v[g], tmp);
        end
        wait_idle();

        // reset during the second RUN cycle aborts with no done
        f = rnd_frame(1'b0, 1'b0);
        start_frame(f);
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete(sb.size() - 1);
        #1;
        for (int g = 0; g < 4; g++) chkv($sformatf("abort_res%0d", g), res_v[g], '0);
        chki("abort_busy", int'(busy_v), 0);
        chki("abort_done", int'(done_v), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (NP + 4) @(posedge clk);
        #1 chki("abort_idle_busy", int'(busy_v), 0);

        f = rnd_frame(1'b0, 1'b1);
        start_frame(f);
        wait_idle();

        chki("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
